// File: rtl/ram_access_pkg.sv
// Shared types and helpers for the RAM access unit: size encoding, FSM states,
// and the byte-lane mask used for both loads and stores.
package ram_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  // Byte lanes touched by an access of the given size at the given lane offset.
  function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] lane);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      SZ_BYTE: m = 4'b0001 << lane;
      SZ_HALF: m = 4'b0011 << lane;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load data alignment: moves the addressed lane down to bit 0, then truncates
// to the access size and sign- or zero-extends to 32 bits.
module load_extend
  import ram_access_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  offset_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;

  // Right-align the addressed lane and extend per size/signedness.
  always_comb begin
    shifted  = data_i >> {offset_i, 3'b000};
    result_o = shifted;
    case (size_i)
      SZ_BYTE: result_o = unsigned_i ? {24'b0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: result_o = unsigned_i ? {16'b0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      default: result_o = shifted;
    endcase
  end

endmodule

// File: rtl/ram_access_unit.sv
// CPU load/store front end for a word-organised RAM with byte-lane enables.
// Legal accesses take IDLE -> ACCESS -> RESP; faulting requests skip ACCESS
// so the RAM is never touched by them.
//
//   state  | meaning
//   IDLE   | ready for a request; fields latched on acceptance
//   ACCESS | address/mask/write presented to RAM for one cycle
//   RESP   | one-cycle completion pulse with load data or error
module ram_access_unit
  import ram_access_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned RAM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic        memWrite,
  output logic [3:0]  byteMask,
  input  logic [31:0] memReadData
);

  state_e      state_q;
  logic [29:0] off_hi_q;
  logic [1:0]  addr_lo_q;
  size_e       size_q;
  logic        write_q;
  logic        unsigned_q;
  logic [31:0] wdata_q;
  logic        err_q;

  logic [31:0] off_d;
  logic        err_d;
  logic [31:0] wmask;
  logic [31:0] load_data;

  // Decode window offset and fault conditions of the incoming request.
  always_comb begin
    off_d = req_addr - BASE_ADDR;
    err_d = 1'b0;
    if (off_d >= RAM_BYTES) err_d = 1'b1;
    case (size_e'(req_size))
      SZ_HALF: if (req_addr[0]) err_d = 1'b1;
      SZ_WORD: if (req_addr[1:0] != 2'b00) err_d = 1'b1;
      SZ_ILL:  err_d = 1'b1;
      default: ;
    endcase
  end

  // Sequencer: latches the request on acceptance and walks the access phases.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      off_hi_q   <= '0;
      addr_lo_q  <= '0;
      size_q     <= SZ_BYTE;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            off_hi_q   <= off_d[31:2];
            addr_lo_q  <= req_addr[1:0];
            size_q     <= size_e'(req_size);
            write_q    <= req_write;
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata;
            err_q      <= err_d;
            state_q    <= err_d ? ST_RESP : ST_ACCESS;
          end
        end
        ST_ACCESS: state_q <= ST_RESP;
        ST_RESP:   state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Size mask keeps unused store lanes at zero after positioning.
  always_comb begin
    case (size_q)
      SZ_BYTE: wmask = 32'h0000_00FF;
      SZ_HALF: wmask = 32'h0000_FFFF;
      default: wmask = 32'hFFFF_FFFF;
    endcase
  end

  load_extend u_load_extend (
    .data_i     (memReadData),
    .offset_i   (addr_lo_q),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .result_o   (load_data)
  );

  // Output decode from the registered state and latched request. The write
  // enable is also gated by reset so a store overlapping reset never commits.
  always_comb begin
    req_ready    = (state_q == ST_IDLE);
    rsp_valid    = (state_q == ST_RESP);
    rsp_err      = (state_q == ST_RESP) && err_q;
    rsp_rdata    = ((state_q == ST_RESP) && !err_q && !write_q) ? load_data : 32'h0;
    memAddress   = {2'b00, off_hi_q};
    memWriteData = (wdata_q & wmask) << {addr_lo_q, 3'b000};
    memWrite     = (state_q == ST_ACCESS) && write_q && !reset;
    byteMask     = (state_q == ST_ACCESS) ? lane_mask(size_q, addr_lo_q) : 4'b0000;
  end

endmodule

// File: tb/tb_ram_access_unit.sv
// Directed bench for ram_access_unit with a small byte-lane RAM model.
module tb_ram_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWrite;
  logic [3:0]  byteMask;
  logic [31:0] memReadData;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [256] = '{default: '0};

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  mask;
    logic [31:0] mwdata;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  ram_access_unit #(.BASE_ADDR(32'h0000_0000), .RAM_BYTES(65536)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_rdata    (rsp_rdata),
    .memAddress   (memAddress),
    .memWriteData (memWriteData),
    .memWrite     (memWrite),
    .byteMask     (byteMask),
    .memReadData  (memReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: byte-lane write, read data valid one cycle after the address.
  always @(posedge clk) begin
    if (memWrite) begin
      for (int b = 0; b < 4; b++)
        if (byteMask[b]) mem[memAddress[7:0]][8*b +: 8] <= memWriteData[8*b +: 8];
    end
    memReadData <= mem[memAddress[7:0]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid    = 1'b0;
    req_write    = 1'b1;
    req_size     = 2'b11;
    req_unsigned = 1'b1;
    req_addr     = 32'hFFFF_FFFF;
    req_wdata    = 32'hDEAD_DEAD;
  endtask

  task automatic drive(input vec_t v);
    req_valid    = 1'b1;
    req_write    = v.wr;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
  endtask

  task automatic run_req(input vec_t v, input int id);
    @(negedge clk);
    chk($sformatf("v%0d ready", id), {31'b0, req_ready}, 32'd1);
    drive(v);
    @(negedge clk);
    idle_inputs();
    if (v.err) begin
      chk($sformatf("v%0d err rsp_valid", id), {31'b0, rsp_valid}, 32'd1);
      chk($sformatf("v%0d err rsp_err", id), {31'b0, rsp_err}, 32'd1);
      chk($sformatf("v%0d err rdata", id), rsp_rdata, 32'h0);
      chk($sformatf("v%0d err memWrite", id), {31'b0, memWrite}, 32'd0);
      chk($sformatf("v%0d err mask", id), {28'b0, byteMask}, 32'h0);
    end else begin
      chk($sformatf("v%0d acc rsp_valid", id), {31'b0, rsp_valid}, 32'd0);
      chk($sformatf("v%0d acc memWrite", id), {31'b0, memWrite}, {31'b0, v.wr});
      chk($sformatf("v%0d acc mask", id), {28'b0, byteMask}, {28'b0, v.mask});
      chk($sformatf("v%0d acc wdata", id), memWriteData, v.mwdata);
      chk($sformatf("v%0d acc addr", id), memAddress, v.addr >> 2);
      @(negedge clk);
      chk($sformatf("v%0d rsp_valid", id), {31'b0, rsp_valid}, 32'd1);
      chk($sformatf("v%0d rsp_err", id), {31'b0, rsp_err}, 32'd0);
      chk($sformatf("v%0d rdata", id), rsp_rdata, v.rdata);
      chk($sformatf("v%0d rsp memWrite", id), {31'b0, memWrite}, 32'd0);
      chk($sformatf("v%0d rsp mask", id), {28'b0, byteMask}, 32'h0);
    end
    @(negedge clk);
    chk($sformatf("v%0d post rsp_valid", id), {31'b0, rsp_valid}, 32'd0);
    chk($sformatf("v%0d post rsp_err", id), {31'b0, rsp_err}, 32'd0);
    chk($sformatf("v%0d post rdata", id), rsp_rdata, 32'h0);
    chk($sformatf("v%0d post ready", id), {31'b0, req_ready}, 32'd1);
  endtask

  logic exp_rdy, exp_rv;

  initial begin
    //          wr    size   uns   addr          wdata          err   rdata          mask     mwdata
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1122_3344, 1'b0, 32'h0000_0000, 4'b1111, 32'h1122_3344};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h1122_3344, 4'b1111, 32'h0000_0000};
    vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'hFFFF_FFA5, 1'b0, 32'h0000_0000, 4'b1000, 32'hA500_0000};
    vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_0000, 1'b0, 32'hFFFF_FFA5, 4'b1000, 32'h0000_0000};
    vecs[4]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0000_0000, 1'b0, 32'h0000_00A5, 4'b1000, 32'h0000_0000};
    vecs[5]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h1234_8001, 1'b0, 32'h0000_0000, 4'b1100, 32'h8001_0000};
    vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_0000, 1'b0, 32'hFFFF_8001, 4'b1100, 32'h0000_0000};
    vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0000_0000, 1'b0, 32'h0000_8001, 4'b1100, 32'h0000_0000};
    vecs[8]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_0000, 1'b0, 32'h0000_0033, 4'b0010, 32'h0000_0000};
    vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h0000_3344, 4'b0011, 32'h0000_0000};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0000, 32'h0000_0000};
    vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h0000_0005, 32'h0000_BEEF, 1'b1, 32'h0000_0000, 4'b0000, 32'h0000_0000};
    vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h0001_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0000, 32'h0000_0000};
    vecs[13] = '{1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0000, 32'h0000_0000};
    vecs[14] = '{1'b1, 2'b10, 1'b0, 32'h0000_0042, 32'h5555_5555, 1'b1, 32'h0000_0000, 4'b0000, 32'h0000_0000};
    vecs[15] = '{1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 4'b1111, 32'hCAFE_F00D};

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst ready", {31'b0, req_ready}, 32'd1);
    chk("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst rdata", rsp_rdata, 32'h0);
    chk("rst memWrite", {31'b0, memWrite}, 32'd0);
    chk("rst mask", {28'b0, byteMask}, 32'h0);
    chk("rst mwdata", memWriteData, 32'h0);
    chk("rst maddr", memAddress, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) run_req(vecs[i], i);

    // Reset during the ACCESS cycle of a store to 0x40 (holds 0xCAFEF00D).
    @(negedge clk);
    drive('{1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 32'h0, 4'b1111, 32'hDEAD_BEEF});
    @(negedge clk);
    idle_inputs();
    chk("rstacc memWrite before", {31'b0, memWrite}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rstacc memWrite gated", {31'b0, memWrite}, 32'd0);
    @(negedge clk);
    chk("rstacc ready", {31'b0, req_ready}, 32'd1);
    chk("rstacc rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rstacc memWrite", {31'b0, memWrite}, 32'd0);
    chk("rstacc mask", {28'b0, byteMask}, 32'h0);
    chk("rstacc maddr", memAddress, 32'h0);
    chk("rstacc mwdata", memWriteData, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rstacc no rsp", {31'b0, rsp_valid}, 32'd0);
    chk("rstacc no write", {31'b0, memWrite}, 32'd0);
    run_req('{1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'hCAFE_F00D, 4'b1111, 32'h0}, 100);

    // Back-to-back loads with req_valid held high: ready every third cycle.
    @(negedge clk);
    drive('{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h0, 4'b1111, 32'h0});
    for (int i = 0; i < 9; i++) begin
      exp_rdy = (i % 3 == 0);
      exp_rv  = (i % 3 == 2);
      chk($sformatf("b2b%0d ready", i), {31'b0, req_ready}, {31'b0, exp_rdy});
      chk($sformatf("b2b%0d rsp_valid", i), {31'b0, rsp_valid}, {31'b0, exp_rv});
      if (exp_rv) chk($sformatf("b2b%0d rdata", i), rsp_rdata, 32'hA522_3344);
      if (i == 8) idle_inputs();
      @(negedge clk);
    end
    repeat (3) begin
      chk("b2b drain rsp_valid", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
